// File: rtl/mem_port_arbiter_if.sv
//----------------------------------------------------------------------------
// mem_port_arbiter_if
//
// Purpose: bundles every handshake and bus signal around the memory port
// arbiter: the fetch-stage request port, the memory-stage request port, the
// shared memory port and the two pipeline stall lines.
//
// Parameters:
//   DPW  data and address width
//
// Signal summary:
//   if_req, if_addr             fetch read request (held until if_valid)
//   if_rdata, if_valid          fetched word and one-cycle completion pulse
//   dm_req, dm_we               memory-stage request and write flag
//   dm_addr, dm_wdata           data address and store data
//   dm_rdata, dm_valid          load data and one-cycle completion pulse
//   mem_req, mem_we             shared port request and write enable
//   mem_addr, mem_wdata         shared port address and write data
//   mem_ack, mem_rdata          memory completion strobe and read data
//   stallF, stallM              pipeline stalls for fetch and memory stages
//
// Modports:
//   slave   the arbiter's view (takes requests, drives the memory port)
//   master  the surrounding pipeline and memory's view
//----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int DPW = 32
);
    logic           if_req;
    logic [DPW-1:0] if_addr;
    logic [DPW-1:0] if_rdata;
    logic           if_valid;

    logic           dm_req;
    logic           dm_we;
    logic [DPW-1:0] dm_addr;
    logic [DPW-1:0] dm_wdata;
    logic [DPW-1:0] dm_rdata;
    logic           dm_valid;

    logic           mem_req;
    logic           mem_we;
    logic [DPW-1:0] mem_addr;
    logic [DPW-1:0] mem_wdata;
    logic           mem_ack;
    logic [DPW-1:0] mem_rdata;

    logic           stallF;
    logic           stallM;

    modport slave (
        input  if_req, if_addr,
        input  dm_req, dm_we, dm_addr, dm_wdata,
        input  mem_ack, mem_rdata,
        output if_rdata, if_valid,
        output dm_rdata, dm_valid,
        output mem_req, mem_we, mem_addr, mem_wdata,
        output stallF, stallM
    );

    modport master (
        output if_req, if_addr,
        output dm_req, dm_we, dm_addr, dm_wdata,
        output mem_ack, mem_rdata,
        input  if_rdata, if_valid,
        input  dm_rdata, dm_valid,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        input  stallF, stallM
    );
endinterface

// File: rtl/mem_port_arbiter.sv
//----------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose: shares one single-outstanding memory port between the fetch stage
// and the memory stage of a pipeline. The data side has fixed priority; an
// optional starvation guard forces a fetch grant after STARVE_MAX consecutive
// data grants made while fetch was waiting.
//
// Parameters:
//   DPW         data and address width
//   STARVE_MAX  consecutive data grants tolerated while fetch waits
//
// Ports:
//   clk     rising-edge clock
//   arst_n  asynchronous active-low reset
//   bus     mem_port_arbiter_if.slave, all request/response/stall signals
//
// Configuration:
//   ARB_STARVE_GUARD_EN  when defined, builds the starvation counter; when
//                        undefined, arbitration is pure data-first priority
//                        and STARVE_MAX has no effect.
//----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int DPW        = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                 clk,
    input  logic                 arst_n,
    mem_port_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t         state;
    state_t         state_next;
    logic           grant_i;
    logic           grant_d;
    logic           fetch_first;

    logic           mem_req_q;
    logic           mem_we_q;
    logic [DPW-1:0] mem_addr_q;
    logic [DPW-1:0] mem_wdata_q;
    logic [DPW-1:0] if_rdata_q;
    logic           if_valid_q;
    logic [DPW-1:0] dm_rdata_q;
    logic           dm_valid_q;

    // A negative threshold has no meaning in either build.
    if (STARVE_MAX < 0) begin : g_bad_starve_max
        $error("mem_port_arbiter: STARVE_MAX must not be negative");
    end

`ifdef ARB_STARVE_GUARD_EN
    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_cnt;

    // The counter only advances while fetch is waiting, and at STARVE_MAX
    // a waiting fetch always wins, so it can never run past STARVE_MAX.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            starve_cnt <= '0;
        end else if (grant_i) begin
            starve_cnt <= '0;
        end else if (grant_d && bus.if_req) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    assign fetch_first = bus.if_req && (starve_cnt == CNT_W'(STARVE_MAX));
`else
    assign fetch_first = 1'b0;
`endif

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Grants are only made from IDLE, so every completion is followed by at
    // least one IDLE cycle. A request still high in that IDLE cycle counts
    // as the requester's next transaction.
    always_comb begin
        state_next = state;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.dm_req && !fetch_first) begin
                    grant_d    = 1'b1;
                    state_next = BUSY_D;
                end else if (bus.if_req) begin
                    grant_i    = 1'b1;
                    state_next = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (bus.mem_ack) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Memory-port request fields are captured on the grant and left alone
    // until the ack, so a requester may drop its request after the grant
    // and the transaction still runs to completion. An ack in IDLE falls
    // through every branch and is ignored.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            if_valid_q  <= 1'b0;
            dm_rdata_q  <= '0;
            dm_valid_q  <= 1'b0;
        end else begin
            if_valid_q <= 1'b0;
            dm_valid_q <= 1'b0;
            if (grant_d) begin
                mem_req_q   <= 1'b1;
                mem_we_q    <= bus.dm_we;
                mem_addr_q  <= bus.dm_addr;
                mem_wdata_q <= bus.dm_wdata;
            end else if (grant_i) begin
                mem_req_q   <= 1'b1;
                mem_we_q    <= 1'b0;
                mem_addr_q  <= bus.if_addr;
                mem_wdata_q <= '0;
            end else if ((state != IDLE) && bus.mem_ack) begin
                mem_req_q <= 1'b0;
                mem_we_q  <= 1'b0;
                if (state == BUSY_I) begin
                    if_rdata_q <= bus.mem_rdata;
                    if_valid_q <= 1'b1;
                end else begin
                    dm_valid_q <= 1'b1;
                    if (!mem_we_q) begin
                        dm_rdata_q <= bus.mem_rdata;
                    end
                end
            end
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_valid  = if_valid_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.dm_valid  = dm_valid_q;

    // The stall lines release in the same cycle the completion pulse shows.
    assign bus.stallF = bus.if_req & ~if_valid_q;
    assign bus.stallM = bus.dm_req & ~dm_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
//----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Purpose: self-checking bench for mem_port_arbiter. Two requester agents
// (fetch and data) work through transaction queues, a memory model answers
// the shared port after a programmable latency, and a scoreboard holds the
// expected grant order and expected read data for every transaction.
// Builds with or without ARB_STARVE_GUARD_EN; the expected grant order of
// the starvation scenario follows the macro.
//----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int DPW = 32;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD_EN = 1'b1;
`else
    localparam bit GUARD_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          life;
        bit          hold;
        bit          chk_lat;
    } txn_t;

    typedef struct {
        bit          is_d;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } grant_t;

    logic clk;
    logic arst_n;

    mem_port_arbiter_if #(.DPW(DPW)) bus ();

    mem_port_arbiter #(
        .DPW        (DPW),
        .STARVE_MAX (4)
    ) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    txn_t        f_q[$];
    txn_t        d_q[$];
    grant_t      g_q[$];
    grant_t      cur_g;
    bit          f_granted, d_granted, f_active, d_active;
    int          f_age, d_age, f_start, d_start;
    int          f_valid_step, d_valid_step;
    int          step_no;
    int          mem_lat, mem_cnt;
    bit          force_ack;
    logic [31:0] dm_model;
    int          n_checks, n_pass;

    // Memory contents seen by reads; 0x100 holds the fetch test instruction.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'h0050_0093;
        return (a * 32'h0001_0003) ^ 32'hC3A5_0F0F;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    endtask

    task automatic push_fetch(input logic [31:0] a, input int life, input bit chk_lat);
        f_q.push_back('{a, 1'b0, 32'h0, mem_word(a), life, 1'b1, chk_lat});
    endtask

    task automatic push_data(input logic [31:0] a, input logic we, input logic [31:0] wd,
                             input int life, input bit hold);
        logic [31:0] exp;
        exp = we ? dm_model : mem_word(a);
        if (!we) dm_model = mem_word(a);
        d_q.push_back('{a, we, wd, exp, life, hold, 1'b0});
    endtask

    task automatic expect_grant(input bit is_d, input logic [31:0] a, input logic we,
                                input logic [31:0] wd);
        g_q.push_back('{is_d, a, we, wd});
    endtask

    // Memory model, completion monitors and grant monitor.
    task automatic observe();
        if (bus.mem_ack) checkOutput("req_low_after_ack", 32'(bus.mem_req), 32'd0);
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = $urandom();

        if (bus.if_valid) begin
            if (f_q.size() > 0 && f_granted) begin
                checkOutput("if_rdata", bus.if_rdata, f_q[0].exp_rdata);
                if (f_q[0].chk_lat) checkOutput("if_valid_latency", 32'(step_no - f_start), 32'd4);
                void'(f_q.pop_front());
                f_granted = 1'b0; f_active = 1'b0; f_valid_step = step_no;
            end else checkOutput("if_valid_spurious", 32'd1, 32'd0);
        end
        if (bus.dm_valid) begin
            if (d_q.size() > 0 && d_granted) begin
                checkOutput("dm_rdata", bus.dm_rdata, d_q[0].exp_rdata);
                void'(d_q.pop_front());
                d_granted = 1'b0; d_active = 1'b0; d_valid_step = step_no;
            end else checkOutput("dm_valid_spurious", 32'd1, 32'd0);
        end

        if (bus.mem_req) begin
            mem_cnt++;
            if (mem_cnt == 1) begin
                if (g_q.size() == 0) begin
                    checkOutput("unexpected_grant", 32'd1, 32'd0);
                    cur_g = '{1'b0, bus.mem_addr, bus.mem_we, bus.mem_wdata};
                end else begin
                    cur_g = g_q.pop_front();
                    checkOutput("grant_addr", bus.mem_addr, cur_g.addr);
                    checkOutput("grant_we", 32'(bus.mem_we), 32'(cur_g.we));
                    if (cur_g.we) checkOutput("grant_wdata", bus.mem_wdata, cur_g.wdata);
                    if (cur_g.is_d) d_granted = 1'b1;
                    else begin
                        f_granted = 1'b1;
                        if (f_q.size() > 0 && f_q[0].chk_lat)
                            checkOutput("grant_latency", 32'(step_no - f_start), 32'd1);
                    end
                end
            end
            if (mem_cnt == mem_lat + 1) begin
                checkOutput("hold_addr", bus.mem_addr, cur_g.addr);
                checkOutput("hold_we", 32'(bus.mem_we), 32'(cur_g.we));
                if (cur_g.we) checkOutput("hold_wdata", bus.mem_wdata, cur_g.wdata);
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = cur_g.we ? 32'hBAD0_BAD0 : mem_word(cur_g.addr);
            end
        end else begin
            mem_cnt = 0;
        end

        if (force_ack) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = 32'h1234_5678;
            force_ack     = 1'b0;
        end
    endtask

    // Requester agents: present the head transaction, abandon it after
    // 'life' ungranted cycles, or drop the request after grant when !hold.
    task automatic applyStimulus();
        if (f_q.size() > 0) begin
            if (!f_active) begin f_active = 1'b1; f_start = step_no; f_age = 0; end
            else if (!f_granted) f_age++;
            if (!f_granted && f_q[0].life > 0 && f_age >= f_q[0].life) begin
                void'(f_q.pop_front());
                f_active = 1'b0;
                bus.if_req = 1'b0;
            end else begin
                bus.if_req  = !(f_granted && !f_q[0].hold);
                bus.if_addr = f_q[0].addr;
            end
        end else bus.if_req = 1'b0;

        if (d_q.size() > 0) begin
            if (!d_active) begin d_active = 1'b1; d_start = step_no; d_age = 0; end
            else if (!d_granted) d_age++;
            if (!d_granted && d_q[0].life > 0 && d_age >= d_q[0].life) begin
                void'(d_q.pop_front());
                d_active = 1'b0;
                bus.dm_req = 1'b0;
            end else begin
                bus.dm_req   = !(d_granted && !d_q[0].hold);
                bus.dm_we    = d_q[0].we;
                bus.dm_addr  = d_q[0].addr;
                bus.dm_wdata = d_q[0].wdata;
            end
        end else bus.dm_req = 1'b0;
    endtask

    task automatic runCycle();
        @(posedge clk);
        #1;
        step_no++;
        observe();
        applyStimulus();
        #1;
    endtask

    function automatic bit is_idle();
        return (f_q.size() == 0) && (d_q.size() == 0) && (g_q.size() == 0) && !bus.mem_req;
    endfunction

    task automatic drain(input string tag, input int max_cycles);
        int n;
        n = 0;
        while (!is_idle() && n < max_cycles) begin
            runCycle();
            n++;
        end
        checkOutput(tag, is_idle() ? 32'd1 : 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        n_checks = 0; n_pass = 0; step_no = 0; mem_lat = 2; mem_cnt = 0;
        force_ack = 1'b0; dm_model = 32'h0;
        f_granted = 1'b0; d_granted = 1'b0; f_active = 1'b0; d_active = 1'b0;
        f_age = 0; d_age = 0; f_start = 0; d_start = 0; f_valid_step = 0; d_valid_step = 0;
        cur_g = '{1'b0, 32'h0, 1'b0, 32'h0};
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        arst_n = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_mem_req", 32'(bus.mem_req), 32'd0);
        checkOutput("rst_mem_we", 32'(bus.mem_we), 32'd0);
        checkOutput("rst_mem_addr", bus.mem_addr, 32'd0);
        checkOutput("rst_mem_wdata", bus.mem_wdata, 32'd0);
        checkOutput("rst_if_valid", 32'(bus.if_valid), 32'd0);
        checkOutput("rst_if_rdata", bus.if_rdata, 32'd0);
        checkOutput("rst_dm_valid", 32'(bus.dm_valid), 32'd0);
        checkOutput("rst_dm_rdata", bus.dm_rdata, 32'd0);
        @(negedge clk);
        arst_n = 1'b1;

        // Fetch only: latency and stallF window.
        $display("[TB] fetch only");
        mem_lat = 2;
        push_fetch(32'h100, 0, 1'b1);
        expect_grant(1'b0, 32'h100, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            runCycle();
            checkOutput($sformatf("stallF_t%0d", i), 32'(bus.stallF), (i < 4) ? 32'd1 : 32'd0);
        end
        drain("drain_fetch_only", 50);

        // Simultaneous requests: data first, then fetch.
        $display("[TB] simultaneous requests");
        push_fetch(32'h300, 0, 1'b0);
        push_data(32'h2000, 1'b0, 32'h0, 0, 1'b1);
        expect_grant(1'b1, 32'h2000, 1'b0, 32'h0);
        expect_grant(1'b0, 32'h300, 1'b0, 32'h0);
        drain("drain_simultaneous", 50);
        checkOutput("dm_valid_before_if_valid", (d_valid_step < f_valid_step) ? 32'd1 : 32'd0, 32'd1);

        // Load then store: store keeps dm_rdata from the load.
        $display("[TB] store");
        push_data(32'h44, 1'b0, 32'h0, 0, 1'b1);
        push_data(32'h40, 1'b1, 32'hDEAD_BEEF, 0, 1'b1);
        expect_grant(1'b1, 32'h44, 1'b0, 32'h0);
        expect_grant(1'b1, 32'h40, 1'b1, 32'hDEAD_BEEF);
        drain("drain_store", 50);

        // Starvation: data held continuously while fetch waits.
        $display("[TB] starvation");
        mem_lat = 1;
        push_fetch(32'h400, 0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            push_data(32'h1000 + 32'(4 * i), 1'b0, 32'h0, 0, 1'b1);
            if (GUARD_EN && i == 4) expect_grant(1'b0, 32'h400, 1'b0, 32'h0);
            expect_grant(1'b1, 32'h1000 + 32'(4 * i), 1'b0, 32'h0);
        end
        if (!GUARD_EN) expect_grant(1'b0, 32'h400, 1'b0, 32'h0);
        drain("drain_starvation", 100);

        // Dropped before grant, and dropped after grant.
        $display("[TB] request withdrawal");
        mem_lat = 3;
        push_data(32'h3000, 1'b0, 32'h0, 0, 1'b1);
        push_fetch(32'h500, 2, 1'b0);
        expect_grant(1'b1, 32'h3000, 1'b0, 32'h0);
        drain("drain_drop_before_grant", 50);
        push_data(32'h3004, 1'b0, 32'h0, 0, 1'b0);
        expect_grant(1'b1, 32'h3004, 1'b0, 32'h0);
        drain("drain_drop_after_grant", 50);

        // Ack while idle is ignored.
        $display("[TB] ack in idle");
        runCycle();
        force_ack = 1'b1;
        runCycle();
        runCycle();
        checkOutput("idle_ack_no_valid", {30'd0, bus.if_valid, bus.dm_valid}, 32'd0);
        checkOutput("idle_ack_no_req", 32'(bus.mem_req), 32'd0);

        // Reset in the middle of a data read, then re-issue.
        $display("[TB] reset mid-transaction");
        mem_lat = 5;
        push_data(32'h6000, 1'b0, 32'h0, 0, 1'b1);
        expect_grant(1'b1, 32'h6000, 1'b0, 32'h0);
        n = 0;
        while (!d_granted && n < 20) begin
            runCycle();
            n++;
        end
        checkOutput("abort_target_granted", 32'(d_granted), 32'd1);
        runCycle();
        #2;
        arst_n = 1'b0;
        #1;
        checkOutput("abort_mem_req", 32'(bus.mem_req), 32'd0);
        checkOutput("abort_mem_we", 32'(bus.mem_we), 32'd0);
        checkOutput("abort_mem_addr", bus.mem_addr, 32'd0);
        checkOutput("abort_mem_wdata", bus.mem_wdata, 32'd0);
        checkOutput("abort_dm_rdata", bus.dm_rdata, 32'd0);
        checkOutput("abort_if_rdata", bus.if_rdata, 32'd0);
        checkOutput("abort_stallM", 32'(bus.stallM), 32'd1);
        d_granted = 1'b0; d_active = 1'b0; mem_cnt = 0; bus.mem_ack = 1'b0;
        expect_grant(1'b1, 32'h6000, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        checkOutput("abort_hold_mem_req", 32'(bus.mem_req), 32'd0);
        checkOutput("abort_no_dm_valid", 32'(bus.dm_valid), 32'd0);
        #2;
        arst_n = 1'b1;
        runCycle();
        checkOutput("regrant_first_edge", 32'(bus.mem_req), 32'd1);
        drain("drain_reissue", 50);

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
